// File: rtl/moving_average_filter_pkg.sv
// Shared types and widths for the boxcar filter stage of the adaptive filter chain.
// Holds the default sample width and the two-state control encoding.
package moving_average_filter_pkg;

  localparam int AFC_DATA_W   = 24;
  localparam int DEF_LOG2_LEN = 4;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/moving_average_filter_sample_ram.sv
// Window sample store: 2**ADDR_W x DATA_W, one synchronous write port, async read, no reset.
// Latency 0 on read and 1 on write. It has no flow control; the owner decides when to write.
module moving_average_filter_sample_ram
  import moving_average_filter_pkg::*;
#(
  parameter int DATA_W = AFC_DATA_W,
  parameter int ADDR_W = DEF_LOG2_LEN
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/moving_average_filter.sv
// N-tap boxcar low-pass filter with a running sum over a zero-filled circular window. Latency is 1 cycle.
// Input stalls while a held output is unconsumed, and for N cycles of buffer clear after reset or flush.
module moving_average_filter
  import moving_average_filter_pkg::*;
#(
  parameter int DATA_W   = AFC_DATA_W,
  parameter int LOG2_LEN = DEF_LOG2_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int SUM_W = DATA_W + LOG2_LEN;

  state_t                     state, state_nxt;
  logic [LOG2_LEN-1:0]        clr_addr;
  logic [LOG2_LEN-1:0]        wr_ptr;
  logic signed [SUM_W-1:0]    sum;
  logic signed [SUM_W-1:0]    sum_nxt;
  logic signed [SUM_W-1:0]    in_ext;
  logic signed [SUM_W-1:0]    old_ext;
  logic [DATA_W-1:0]          old_dat;
  logic                       accept;
  logic                       ram_we;
  logic [LOG2_LEN-1:0]        ram_waddr;
  logic [DATA_W-1:0]          ram_wdata;

  moving_average_filter_sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (LOG2_LEN)
  ) u_sample_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (wr_ptr),
    .rdata (old_dat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Clearing writes zeros through the same port the run path uses for samples.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = wr_ptr;
    ram_wdata = in_data;
    case (state)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr;
        ram_wdata = '0;
        if (&clr_addr) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        in_ready = !out_valid || out_ready;
        ram_we   = in_valid && in_ready && !flush;
      end
      default: state_nxt = S_CLEAR;
    endcase
    if (flush) begin
      state_nxt = S_CLEAR;
      in_ready  = 1'b0;
    end
  end

  assign accept  = in_valid && in_ready;
  assign in_ext  = {{LOG2_LEN{in_data[DATA_W-1]}}, in_data};
  assign old_ext = {{LOG2_LEN{old_dat[DATA_W-1]}}, old_dat};
  // The sum carries LOG2_LEN guard bits, so N full-scale samples cannot overflow it.
  assign sum_nxt = sum + in_ext - old_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_addr  <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      clr_addr  <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == S_CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
        sum      <= '0;
      end
      if (accept) begin
        wr_ptr    <= wr_ptr + 1'b1;
        sum       <= sum_nxt;
        // Dropping the low LOG2_LEN bits of a signed sum is a floor divide by N.
        out_data  <= sum_nxt[SUM_W-1:LOG2_LEN];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
